mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, giving the address width of all address ports.
REQ-002 The block SHALL have parameter DATA_W, default 32, giving the width of all data ports.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 if_req  input  1  fetch request; if_addr  input  ADDR_W  fetch address. The fetch port is read-only.
REQ-006 if_gnt  output  1  one-cycle pulse: fetch access issued; if_rvalid  output  1  one-cycle pulse: if_rdata valid; if_rdata  output  DATA_W  fetch read data.
REQ-007 ls_req  input  1  load/store request; ls_we  input  1  1=store, 0=load; ls_addr  input  ADDR_W; ls_wdata  input  DATA_W  store data.
REQ-008 ls_gnt  output  1; ls_rvalid  output  1; ls_rdata  output  DATA_W; same meaning as the fetch equivalents.
REQ-009 mem_addr  output  ADDR_W; mem_data_out  output  DATA_W  write data to memory; mem_ren  output  1; mem_wen  output  1; mem_data_in  input  DATA_W  memory read data, valid one cycle after the cycle in which mem_ren is high.
REQ-010 All outputs SHALL be registered.

Function
REQ-011 FSM states SHALL be IDLE, ACCESS and RESP.
REQ-012 In IDLE with at least one req high at a clock edge: latch the winner's owner, address, we and wdata; go to ACCESS. With no req high: stay in IDLE.
REQ-013 In ACCESS (exactly one cycle): mem_addr and mem_data_out SHALL carry the latched values; mem_ren=!we or mem_wen=we; the winner's gnt=1.
REQ-014 ACCESS SHALL go to RESP for a read and to IDLE for a write. A write produces no rvalid.
REQ-015 In RESP (exactly one cycle): capture mem_data_in into the owner's rdata register; go to IDLE; the owner's rvalid SHALL be 1 in the following cycle only.
REQ-016 Read latency: a req sampled at edge N gives gnt in cycle N+1 and rvalid in cycle N+3. Write: gnt and mem_wen in cycle N+1.
REQ-017 The cycle in which rvalid is high is an IDLE cycle, so a new request SHALL be sampled at its closing edge. Back-to-back reads therefore run every 3 cycles and back-to-back writes every 2 cycles.
REQ-018 Requesters SHALL hold req and payload stable until gnt. A request is committed once latched; dropping req afterwards SHALL NOT cancel it.
REQ-019 A requester whose req is high in the same cycle as its own gnt SHALL be treated as a new request.
REQ-020 Outside ACCESS: mem_ren=mem_wen=0; mem_addr and mem_data_out hold their last value.
REQ-021 rdata registers SHALL hold their value until the next read completes for that port.
REQ-022 Never more than one gnt, rvalid, mem_ren or mem_wen SHALL be high in any cycle, and mem_ren and mem_wen SHALL never be high together.

Reset
REQ-023 rst low SHALL immediately force state IDLE, clear owner and last-grant state, and set all outputs to 0 (including mem_addr, mem_data_out and both rdata).
REQ-024 Reset during ACCESS or RESP SHALL abort the transfer: no gnt or rvalid follows, and the requester must re-request.
REQ-025 First arbitration SHALL occur at the first rising edge after rst goes high.

Configuration
REQ-026 Macro MEM_ARBITER_RR_EN SHALL select round-robin arbitration: on simultaneous requests, grant the port not granted most recently; after reset, ls wins first.
REQ-027 Without MEM_ARBITER_RR_EN, arbitration SHALL be fixed priority with ls winning every tie. A lone request SHALL be granted in both modes.

Verification
REQ-028 Reset release, if_req=1, if_addr=0x10, mem_data_in=0xDEADBEEF in the RESP cycle -> if_gnt and mem_ren in cycle 1, if_rvalid=1 with if_rdata=0xDEADBEEF in cycle 3.
REQ-029 ls_req=1, ls_we=1, addr=0x20, wdata=0x12345678 -> one cycle with mem_wen=1, mem_addr=0x20, mem_data_out=0x12345678, ls_gnt=1; no ls_rvalid.
REQ-030 if_req and ls_req held high for 12 cycles -> without the macro, only ls is granted; with the macro, grants alternate ls, if, ls, if.
REQ-031 rst asserted during RESP of a fetch -> all outputs 0 immediately; no if_rvalid after release until a new request completes.
REQ-032 Continuous reads and writes on both ports for 1000 cycles with a memory model -> all read data matches the model, and the one-hot invariants of REQ-022 are never violated.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between a read-only fetch port and a
// load/store port. Ports: clk, rst (async, active-low); fetch if_req/if_addr ->
// if_gnt/if_rvalid/if_rdata; load/store ls_req/ls_we/ls_addr/ls_wdata ->
// ls_gnt/ls_rvalid/ls_rdata; memory mem_addr/mem_data_out/mem_ren/mem_wen,
// mem_data_in (read data one cycle after mem_ren). All outputs registered.
// Build option: MEM_ARBITER_RR_EN selects round-robin, otherwise ls has priority.
`timescale 1ns/1ps
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_out,
    output logic              mem_ren,
    output logic              mem_wen,
    input  logic [DATA_W-1:0] mem_data_in
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state, state_d;
    logic              owner, owner_d;   // 1: load/store port owns the transfer
    logic              pick_ls;
    logic              if_gnt_d, ls_gnt_d;
    logic              if_rvalid_d, ls_rvalid_d;
    logic [DATA_W-1:0] if_rdata_d, ls_rdata_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [DATA_W-1:0] mem_data_out_d;
    logic              mem_ren_d, mem_wen_d;
`ifdef MEM_ARBITER_RR_EN
    logic              last_ls, last_ls_d;
`endif

    // Winner among pending requests; when only if_req is high this is 0.
    always_comb begin
`ifdef MEM_ARBITER_RR_EN
        pick_ls = ls_req && (!if_req || !last_ls);
`else
        pick_ls = ls_req;
`endif
    end

    // Outputs are computed one state ahead so that they leave flops.
    always_comb begin
        state_d        = state;
        owner_d        = owner;
        if_gnt_d       = 1'b0;
        ls_gnt_d       = 1'b0;
        if_rvalid_d    = 1'b0;
        ls_rvalid_d    = 1'b0;
        if_rdata_d     = if_rdata;
        ls_rdata_d     = ls_rdata;
        mem_addr_d     = mem_addr;
        mem_data_out_d = mem_data_out;
        mem_ren_d      = 1'b0;
        mem_wen_d      = 1'b0;
`ifdef MEM_ARBITER_RR_EN
        last_ls_d      = last_ls;
`endif
        unique case (state)
            IDLE: begin
                if (if_req || ls_req) begin
                    state_d = ACCESS;
                    owner_d = pick_ls;
`ifdef MEM_ARBITER_RR_EN
                    last_ls_d = pick_ls;
`endif
                    if (pick_ls) begin
                        ls_gnt_d       = 1'b1;
                        mem_addr_d     = ls_addr;
                        mem_data_out_d = ls_wdata;
                        mem_ren_d      = !ls_we;
                        mem_wen_d      = ls_we;
                    end else begin
                        // Fetch never writes: mem_data_out keeps its value.
                        if_gnt_d   = 1'b1;
                        mem_addr_d = if_addr;
                        mem_ren_d  = 1'b1;
                    end
                end
            end
            ACCESS: begin
                state_d = mem_wen ? IDLE : RESP;
            end
            RESP: begin
                state_d = IDLE;
                if (owner) begin
                    ls_rdata_d  = mem_data_in;
                    ls_rvalid_d = 1'b1;
                end else begin
                    if_rdata_d  = mem_data_in;
                    if_rvalid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            owner        <= 1'b0;
            if_gnt       <= 1'b0;
            ls_gnt       <= 1'b0;
            if_rvalid    <= 1'b0;
            ls_rvalid    <= 1'b0;
            if_rdata     <= '0;
            ls_rdata     <= '0;
            mem_addr     <= '0;
            mem_data_out <= '0;
            mem_ren      <= 1'b0;
            mem_wen      <= 1'b0;
`ifdef MEM_ARBITER_RR_EN
            last_ls      <= 1'b0;
`endif
        end else begin
            state        <= state_d;
            owner        <= owner_d;
            if_gnt       <= if_gnt_d;
            ls_gnt       <= ls_gnt_d;
            if_rvalid    <= if_rvalid_d;
            ls_rvalid    <= ls_rvalid_d;
            if_rdata     <= if_rdata_d;
            ls_rdata     <= ls_rdata_d;
            mem_addr     <= mem_addr_d;
            mem_data_out <= mem_data_out_d;
            mem_ren      <= mem_ren_d;
            mem_wen      <= mem_wen_d;
`ifdef MEM_ARBITER_RR_EN
            last_ls      <= last_ls_d;
`endif
        end
    end

endmodule
